// File: rtl/wb_byte_mem_bridge.sv
// rtl/wb_byte_mem_bridge.sv - Wishbone-classic 32-bit slave over an 8-bit synchronous byte memory
//
// Each word access becomes four byte accesses at {word, lane}, lane 0..3. A
// trailing cycle collects the last read byte. A fixed one-cycle ack follows.
// Request sampled in cycle 0 -> ack in cycle 6. Throughput is one word per 7 cycles.
//
// Parameters
//   MEM_AW   byte-address width of the memory
//   BIG_END  1: lane 0 is bits [31:24]; 0: lane 0 is bits [7:0]
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   wb_cyc_i      bus cycle valid; dropping it mid-access aborts without ack
//   wb_stb_i      request strobe, sampled only in IDLE
//   wb_we_i       1 = write
//   wb_adr_i      byte address; [1:0] and bits >= MEM_AW ignored
//   wb_sel_i      byte enables, sel[3] = bits [31:24]
//   wb_dat_i      write data
//   wb_dat_o      read data; holds the last read word until the next read ack
//   wb_ack_o      one-cycle acknowledge
//   mem_adr       memory byte address
//   mem_dat_o     memory write byte
//   mem_dat_i     memory read byte, valid one cycle after mem_en
//   mem_we        memory write enable
//   mem_en        memory enable

module wb_byte_mem_bridge #(
  parameter int MEM_AW  = 14,
  parameter bit BIG_END = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [7:0]        mem_dat_o,
  input  logic [7:0]        mem_dat_i,
  output logic              mem_we,
  output logic              mem_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [1:0]        cnt;
  logic [MEM_AW-3:0] word_adr;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [31:0]       rbuf;
  logic [31:0]       rd_word;
  logic [1:0]        pos;
  logic [1:0]        cap_pos;
  logic              start;

  // Address bits outside the word index are aliased away on purpose.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:MEM_AW], wb_adr_i[1:0]};

  // Position of a memory lane inside the 32-bit word (0 = bits [7:0]).
  function automatic logic [1:0] lane_pos(input logic [1:0] lane);
    return BIG_END ? ~lane : lane;
  endfunction

  assign start   = wb_cyc_i & wb_stb_i;
  assign pos     = lane_pos(cnt);
  // Read data trails the address by one cycle, so capture goes to the previous lane.
  assign cap_pos = lane_pos(cnt - 2'd1);

  // Final read word: the buffer with the last byte, still on the bus in TAIL.
  always_comb begin
    rd_word = rbuf;
    rd_word[{lane_pos(2'd3), 3'b000} +: 8] = mem_dat_i;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_XFER;
      S_XFER: begin
        if (!wb_cyc_i) begin
          state_nx = S_IDLE;
        end else if (cnt == 2'd3) begin
          state_nx = S_TAIL;
        end
      end
      S_TAIL: state_nx = wb_cyc_i ? S_ACK : S_IDLE;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latches, lane counter and read assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      word_adr <= '0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      rbuf     <= 32'd0;
      wb_dat_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            word_adr <= wb_adr_i[MEM_AW-1:2];
            we_q     <= wb_we_i;
            sel_q    <= wb_sel_i;
            dat_q    <= wb_dat_i;
            cnt      <= 2'd0;
          end
        end
        S_XFER: begin
          if (wb_cyc_i) begin
            cnt <= cnt + 2'd1;
            if (!we_q && cnt != 2'd0) begin
              rbuf[{cap_pos, 3'b000} +: 8] <= mem_dat_i;
            end
          end
        end
        S_TAIL: begin
          // Loaded here so the word is already stable during the ack cycle.
          if (wb_cyc_i && !we_q) begin
            rbuf     <= rd_word;
            wb_dat_o <= rd_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from state; reset forces IDLE, which zeroes them all.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_dat_o = 8'd0;
    wb_ack_o  = 1'b0;
    case (state)
      S_XFER: begin
        // A dropped cycle must not write the lane in flight.
        mem_en    = wb_cyc_i;
        mem_we    = wb_cyc_i & we_q & sel_q[pos];
        mem_adr   = {word_adr, cnt};
        mem_dat_o = dat_q[{pos, 3'b000} +: 8];
      end
      S_TAIL: begin
        mem_en  = wb_cyc_i;
        mem_adr = {word_adr, 2'b11};
      end
      S_ACK: begin
        wb_ack_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_byte_mem_bridge.sv
// tb/tb_wb_byte_mem_bridge.sv - self-checking bench for wb_byte_mem_bridge

module tb_wb_byte_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Big-endian instance bus
  logic        cyc, stb, we;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        ack;
  logic [13:0] m_adr;
  logic [7:0]  m_do, m_di;
  logic        m_we, m_en;

  // Little-endian instance bus
  logic        cyc1, stb1, we1;
  logic [31:0] adr1, dat_w1, dat_r1;
  logic [3:0]  sel1;
  logic        ack1;
  logic [13:0] m_adr1;
  logic [7:0]  m_do1, m_di1;
  logic        m_we1, m_en1;

  wb_byte_mem_bridge #(.MEM_AW(14), .BIG_END(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
    .mem_adr(m_adr), .mem_dat_o(m_do), .mem_dat_i(m_di),
    .mem_we(m_we), .mem_en(m_en)
  );

  wb_byte_mem_bridge #(.MEM_AW(14), .BIG_END(1'b0)) dut_le (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_we_i(we1), .wb_adr_i(adr1),
    .wb_sel_i(sel1), .wb_dat_i(dat_w1), .wb_dat_o(dat_r1), .wb_ack_o(ack1),
    .mem_adr(m_adr1), .mem_dat_o(m_do1), .mem_dat_i(m_di1),
    .mem_we(m_we1), .mem_en(m_en1)
  );

  logic [7:0]  mem0 [0:16383];
  logic [7:0]  mem1 [0:16383];
  logic [7:0]  sh   [0:16383];
  logic [13:0] wr_log [$];

  int cyc_n  = 0;
  int errors = 0;
  int checks = 0;

  // Expected-behaviour model of the big-endian instance
  bit          act = 1'b0;
  int          c0  = 0;
  logic [13:0] base;
  bit          m_wr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;
  logic [31:0] exp_dout = 32'd0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Byte memories: one-cycle synchronous read
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem0[m_adr] <= m_do;
        wr_log.push_back(m_adr);
      end
      m_di <= mem0[m_adr];
    end
    if (m_en1) begin
      if (m_we1) mem1[m_adr1] <= m_do1;
      m_di1 <= mem1[m_adr1];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc_n);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    int k;
    bit e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dout", dat_r, 32'd0);
        chk("rst_en", 32'(m_en), 32'd0);
        chk("rst_we", 32'(m_we), 32'd0);
        chk("rst_adr", 32'(m_adr), 32'd0);
      end else begin
        k = act ? (cyc_n - c0) : 0;
        if (act && k >= 1 && k <= 5 && !cyc) begin
          chk("abort_we", 32'(m_we), 32'd0);
          chk("abort_ack", 32'(ack), 32'd0);
          act = 1'b0;
        end else if (act && k >= 1 && k <= 4) begin
          e = m_wr && m_sel[4-k];
          chk("xfer_en", 32'(m_en), 32'd1);
          chk("xfer_adr", 32'(m_adr), 32'(base + 14'(k - 1)));
          chk("xfer_we", 32'(m_we), 32'(e));
          chk("xfer_ack", 32'(ack), 32'd0);
          if (e) begin
            chk("xfer_wdata", 32'(m_do), 32'(m_dat[8*(4-k) +: 8]));
            sh[base + 14'(k - 1)] = m_dat[8*(4-k) +: 8];
          end
        end else if (act && k == 5) begin
          chk("tail_en", 32'(m_en), 32'd1);
          chk("tail_we", 32'(m_we), 32'd0);
          chk("tail_adr", 32'(m_adr), 32'(base + 14'd3));
          chk("tail_ack", 32'(ack), 32'd0);
        end else if (act && k == 6) begin
          chk("ack_ack", 32'(ack), 32'd1);
          chk("ack_en", 32'(m_en), 32'd0);
          if (!m_wr) exp_dout = {sh[base], sh[base+14'd1], sh[base+14'd2], sh[base+14'd3]};
          act = 1'b0;
        end else begin
          chk("idle_ack", 32'(ack), 32'd0);
          chk("idle_en", 32'(m_en), 32'd0);
          chk("idle_we", 32'(m_we), 32'd0);
        end
        chk("dout", dat_r, exp_dout);
      end
    end
  end

  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    act = 1'b1; c0 = cyc_n; base = {a[13:2], 2'b00}; m_wr = w; m_sel = s; m_dat = d;
  endtask

  task automatic wait_ack(input string name, output logic [31:0] d);
    int lat;
    lat = -1;
    d = 32'hxxxxxxxx;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = cyc_n - c0;
        d = dat_r;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd6);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    int c1;
    rst = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; dat_w = 0;
    cyc1 = 0; stb1 = 0; we1 = 0; adr1 = 0; sel1 = 0; dat_w1 = 0;
    for (int i = 0; i < 16384; i++) begin
      mem0[i] = 8'(i);
      mem1[i] = 8'(i);
    end
    mem0[16'h2000] = 8'h44; mem0[16'h2001] = 8'h00; mem0[16'h2002] = 8'hBC; mem0[16'h2003] = 8'h00;
    mem1[16'h2000] = 8'h44; mem1[16'h2001] = 8'h00; mem1[16'h2002] = 8'hBC; mem1[16'h2003] = 8'h00;
    for (int i = 16'h10; i < 16'h14; i++) mem0[i] = 8'h00;
    for (int i = 0; i < 16384; i++) sh[i] = mem0[i];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_dout", dat_r, 32'd0);
    chk("reset_en", 32'(m_en), 32'd0);

    // 1) read with mixed bytes
    issue(1'b0, 32'h0000_2000, 4'hF, 32'd0);
    wait_ack("t1", d);
    chk("t1_data", d, 32'h4400BC00);
    idle();

    // 2) partial write then readback
    wr_log.delete();
    issue(1'b1, 32'h0000_0010, 4'b0101, 32'h11223344);
    wait_ack("t2w", d);
    idle();
    chk("t2_wr_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t2_wr_adr0", 32'(wr_log[0]), 32'h11);
      chk("t2_wr_adr1", 32'(wr_log[1]), 32'h13);
    end
    issue(1'b0, 32'h0000_0010, 4'hF, 32'd0);
    wait_ack("t2r", d);
    chk("t2_data", d, 32'h00220044);
    idle();

    // 3) back-to-back reads across the bank boundary, stb held through ack
    issue(1'b0, 32'h0000_07FC, 4'hF, 32'd0);
    wait_ack("t3a", d);
    chk("t3a_data", d, 32'hFCFDFEFF);
    issue(1'b0, 32'h0000_0800, 4'hF, 32'd0);
    wait_ack("t3b", d);
    chk("t3b_data", d, 32'h00010203);
    idle();

    // 4) abort a write at lane 2
    issue(1'b1, 32'h0000_0040, 4'hF, 32'hAABBCCDD);
    repeat (3) @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_mem", {mem0[16'h40], mem0[16'h41], mem0[16'h42], mem0[16'h43]}, 32'hAABB4243);
    chk("t4_dout_kept", dat_r, 32'h00010203);
    issue(1'b0, 32'h0000_0040, 4'hF, 32'd0);
    wait_ack("t4r", d);
    chk("t4_data", d, 32'hAABB4243);
    idle();

    // 5) reset during TAIL of a read
    issue(1'b0, 32'h0000_2000, 4'hF, 32'd0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    act = 1'b0;
    exp_dout = 32'd0;
    #1;
    chk("t5_dout", dat_r, 32'd0);
    chk("t5_en", 32'(m_en), 32'd0);
    chk("t5_adr", 32'(m_adr), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue(1'b0, 32'h0000_07FC, 4'hF, 32'd0);
    wait_ack("t5r", d);
    chk("t5_data", d, 32'hFCFDFEFF);
    idle();

    // 6) little-endian instance, same bytes as test 1
    @(posedge clk);
    #1;
    cyc1 = 1'b1; stb1 = 1'b1; we1 = 1'b0; adr1 = 32'h0000_2000; sel1 = 4'hF;
    c1 = cyc_n;
    lat = -1;
    d = 32'd0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack1) begin
        lat = cyc_n - c1;
        d = dat_r1;
        break;
      end
    end
    chk("t6_latency", 32'(lat), 32'd6);
    chk("t6_data", d, 32'h00BC0044);
    @(posedge clk);
    #1;
    cyc1 = 1'b0; stb1 = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
